// File: rtl/md_sequencer_if.sv
// E-stage to multiply/divide sequencer handshake: issue, operands, read select and HI/LO/stall results.
interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        D_md_use;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;
    logic        stall;

    modport master (
        output start, md_op, A, B, rd_sel, D_md_use,
        input  busy, HI, LO, md_out, stall
    );

    modport slave (
        input  start, md_op, A, B, rd_sel, D_md_use,
        output busy, HI, LO, md_out, stall
    );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO with fixed multi-cycle latency and a D-stage stall request.
// Optional macro MD_CANCEL_EN adds a cancel input that flushes an in-flight or issuing operation.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
`ifdef MD_CANCEL_EN
    input  logic          cancel,
`endif
    md_sequencer_if.slave md
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg;
    logic [31:0] a_reg, b_reg;
    logic [2:0]  op_reg;
    logic [31:0] hi_reg, lo_reg;

    logic cancel_w;
`ifdef MD_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    logic is_long_op, accept, finish;
    assign is_long_op = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
    assign accept     = (state_reg == IDLE) && md.start && !cancel_w;
    assign finish     = (state_reg == RUN) && !cancel_w && (count_reg == 4'd1);

    // Arithmetic on the latched operands; signed divide goes through magnitudes so the
    // most-negative / -1 case wraps cleanly instead of overflowing.
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg, is_sdiv;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign prod_s  = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    assign prod_u  = {32'd0, a_reg} * {32'd0, b_reg};
    assign is_sdiv = (op_reg == OP_DIV);
    assign a_neg   = is_sdiv && a_reg[31];
    assign b_neg   = is_sdiv && b_reg[31];
    assign a_mag   = a_neg ? (32'd0 - a_reg) : a_reg;
    assign b_mag   = b_neg ? (32'd0 - b_reg) : b_reg;
    assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / b_safe;
    assign r_mag   = a_mag % b_safe;
    assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && is_long_op) state_next = RUN;
            RUN:  if (cancel_w || count_reg == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            op_reg    <= 3'd0;
        end else if (accept && is_long_op) begin
            count_reg <= (md.md_op <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            a_reg     <= md.A;
            b_reg     <= md.B;
            op_reg    <= md.md_op;
        end else if (state_reg == RUN) begin
            count_reg <= cancel_w ? 4'd0 : count_reg - 4'd1;
        end
    end

    // Divide by zero still burns the full latency but leaves HI/LO untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (accept && md.md_op == OP_MTHI) begin
            hi_reg <= md.A;
        end else if (accept && md.md_op == OP_MTLO) begin
            lo_reg <= md.A;
        end else if (finish) begin
            case (op_reg)
                OP_MULT: begin
                    hi_reg <= prod_s[63:32];
                    lo_reg <= prod_s[31:0];
                end
                OP_MULTU: begin
                    hi_reg <= prod_u[63:32];
                    lo_reg <= prod_u[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    if (b_reg != 32'd0) begin
                        hi_reg <= rem;
                        lo_reg <= quot;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        md.busy   = (state_reg == RUN);
        md.HI     = hi_reg;
        md.LO     = lo_reg;
        md.md_out = md.rd_sel ? hi_reg : lo_reg;
        md.stall  = md.D_md_use && ((state_reg == RUN) || (md.start && is_long_op));
    end
endmodule

// File: tb/tb_md_sequencer.sv
// Randomized self-checking bench for md_sequencer against a cycle-count reference model of HI/LO.
module tb_md_sequencer;
    logic clk;
    logic reset;
    logic cancel;
    int   n_tests;
    int   n_fail;

    md_sequencer_if mif ();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MD_CANCEL_EN
        .cancel (cancel),
`endif
        .md     (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: remaining busy cycles plus the captured operation.
    int          m_left;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_hi, m_lo;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void apply_result();
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        case (m_op)
            3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'd0, m_a} * {32'd0, m_b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (m_b != 0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
            default: ;
        endcase
    endfunction

    function automatic void model_edge(input logic s, input logic [2:0] op, input logic [31:0] a, b);
        if (!reset) begin
            m_left = 0; m_op = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            if (cancel) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) apply_result();
            end
        end else if (s && !cancel) begin
            if (op >= 1 && op <= 4) begin
                m_op = op; m_a = a; m_b = b;
                m_left = (op <= 2) ? 5 : 10;
            end else if (op == 5) m_hi = a;
            else if (op == 6) m_lo = a;
        end
    endfunction

    task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmu, input logic rs);
        logic exp_stall;
        mif.start = s; mif.md_op = op; mif.A = a; mif.B = b; mif.D_md_use = dmu; mif.rd_sel = rs;
        #1;
        exp_stall = dmu && ((m_left > 0) || (s && op >= 1 && op <= 4));
        check_val("stall", 32'(mif.stall), 32'(exp_stall));
        @(posedge clk);
        model_edge(s, op, a, b);
        #1;
        check_val("busy", 32'(mif.busy), 32'(m_left > 0));
        check_val("hi", mif.HI, m_hi);
        check_val("lo", mif.LO, m_lo);
        check_val("md_out", mif.md_out, rs ? m_hi : m_lo);
        $display("[TB] t=%0t start=%0d op=%0d A=%08h B=%08h busy=%0d HI=%08h LO=%08h stall=%0d",
                 $time, s, op, a, b, mif.busy, mif.HI, mif.LO, mif.stall);
    endtask

    task automatic idle(input int n, input logic dmu);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, dmu, 1'b0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_tests = 0; n_fail = 0;
        m_left = 0; m_op = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
        cancel = 1'b0;
        reset  = 1'b0;
        mif.start = 0; mif.md_op = 0; mif.A = 0; mif.B = 0; mif.D_md_use = 0; mif.rd_sel = 0;
        @(posedge clk); #1;

        // Reset
        idle(2, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        check_val("rst_busy", 32'(mif.busy), 32'd0);
        check_val("rst_hi", mif.HI, 32'd0);
        check_val("rst_md_out", mif.md_out, 32'd0);

        // mult -2 * 3
        step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        idle(5, 1'b0);
        check_val("mult_hi", mif.HI, 32'hFFFF_FFFF);
        check_val("mult_lo", mif.LO, 32'hFFFF_FFFA);
        check_val("mult_busy", 32'(mif.busy), 32'd0);

        // divu 100 / 7 with the D stage waiting
        step(1'b1, 3'd4, 32'd100, 32'd7, 1'b1, 1'b0);
        idle(10, 1'b1);
        check_val("divu_lo", mif.LO, 32'd14);
        check_val("divu_hi", mif.HI, 32'd2);
        check_val("divu_stall_off", 32'(mif.stall), 32'd0);

        // Signed overflow case, then divide by zero
        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(10, 1'b0);
        check_val("div_ovf_lo", mif.LO, 32'h8000_0000);
        check_val("div_ovf_hi", mif.HI, 32'd0);
        step(1'b1, 3'd3, 32'd55, 32'd0, 1'b0, 1'b0);
        idle(9, 1'b0);
        check_val("div0_busy_last", 32'(mif.busy), 32'd1);
        idle(1, 1'b0);
        check_val("div0_lo", mif.LO, 32'h8000_0000);
        check_val("div0_hi", mif.HI, 32'd0);

        // mtlo / mthi
        step(1'b1, 3'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check_val("mtlo_lo", mif.LO, 32'h1234_5678);
        step(1'b1, 3'd5, 32'hCAFE_BABE, 32'd0, 1'b0, 1'b1);
        check_val("mthi_out", mif.md_out, 32'hCAFE_BABE);
        check_val("mthi_busy", 32'(mif.busy), 32'd0);

        // Reset mid-RUN discards the result
        step(1'b1, 3'd1, 32'd7, 32'd9, 1'b0, 1'b0);
        idle(2, 1'b0);
        reset = 1'b0;
        idle(1, 1'b0);
        reset = 1'b1;
        check_val("rst_run_busy", 32'(mif.busy), 32'd0);
        check_val("rst_run_lo", mif.LO, 32'd0);

`ifdef MD_CANCEL_EN
        step(1'b1, 3'd6, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd7, 32'd9, 1'b0, 1'b0);
        idle(2, 1'b0);
        cancel = 1'b1;
        idle(1, 1'b0);
        cancel = 1'b0;
        check_val("cancel_busy", 32'(mif.busy), 32'd0);
        check_val("cancel_lo", mif.LO, 32'hA5A5_0001);
`endif

        // Randomized traffic, including starts while busy and reserved ops
        for (int i = 0; i < 800; i++) begin
            reset  = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
`ifdef MD_CANCEL_EN
            cancel = ($urandom_range(0, 29) == 0);
`endif
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        reset = 1'b1;
        cancel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequencer for the multiply/divide resource in the E stage of the pipelined MIPS core; owns HI/LO and the busy counter.
- Accepts mult/multu/div/divu/mthi/mtlo from E and models fixed multi-cycle latency.
- Produces the md read value (mfhi/mflo) that is carried down the pipe to the W-stage md writeback source.
- Raises a stall request toward the D stage while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 clears state on posedge clk).
- start  in  1  E stage issues the md_op this cycle.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  in  32  rs operand from E.
- B  in  32  rt operand from E.
- rd_sel  in  1  0 selects LO, 1 selects HI for md_out.
- D_md_use  in  1  instruction in D is an md instruction (mult..mtlo, mfhi, mflo).
- busy  out  1  an operation is in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.
- md_out  out  32  rd_sel ? HI : LO (combinational).
- stall  out  1  D_md_use & (busy | (start & md_op in 1..4)).

Behaviour:
- Reset: state IDLE, busy=0, counter=0, HI=0, LO=0, latched operands/op cleared; md_out=0; stall follows its equation (0 unless D_md_use and start).
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 4-bit counter.
- IDLE, start, op 1..4 (edge T):
  - Latch A, B, op.
  - Load counter with MULT_CYCLES or DIV_CYCLES (N).
  - Go to RUN; busy=1 from T+1.
- RUN, each edge:
  - Counter decrements.
  - On the edge where counter==1: write HI/LO, go to IDLE.
  - busy is high for exactly N cycles (T+1..T+N). New HI/LO and busy=0 are both visible at T+N+1.
- Arithmetic (on latched operands):
  - mult: signed 64-bit product; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product; HI=[63:32], LO=[31:0].
  - div: LO=signed quotient (truncate toward zero), HI=remainder with sign of dividend.
  - divu: unsigned quotient/remainder.
- mthi/mtlo in IDLE with start: HI<=A or LO<=A at the same edge. No busy, no RUN entry.
- Divide by zero (B==0): full busy latency still taken; HI and LO unchanged.
- Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored entirely; stall must prevent this. No state, counter or HI/LO change.
- start with op 0/7: no effect.
- md_out is combinational from the current HI/LO. No bypass of an in-flight result; mfhi/mflo are held off by stall.
- Reset low mid-RUN: at that edge go to IDLE, busy=0, HI=LO=0; the in-flight result is discarded.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined: adds input port cancel (1 bit, exception/interrupt flush).
  - cancel=1 in RUN: at that edge go to IDLE, busy=0, HI/LO unchanged.
  - cancel=1 together with start in IDLE: the start is dropped, including mthi/mtlo.
  - cancel has priority below reset.
- Not defined: no cancel port; an operation always runs to completion unless reset is asserted.

Test Plan:
- Reset (reset=0 two cycles), then reset=1 -> busy=0, HI=0, LO=0, md_out=0.
- start, mult, A=0xFFFFFFFE, B=3 at edge T -> busy high T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- start, divu, A=100, B=7, D_md_use=1 held -> stall=1 in the start cycle and all 10 busy cycles; then LO=14, HI=2, stall=0.
- start, div, A=0x80000000, B=0xFFFFFFFF -> after 10 cycles LO=0x80000000, HI=0; then div with B=0 -> 10 busy cycles, HI/LO unchanged.
- mtlo A=0x12345678, next cycle mthi A=0xCAFEBABE -> busy stays 0; LO and HI updated on the respective edges; md_out follows rd_sel.
- mult in flight, reset=0 at cycle 3 -> busy=0 and HI=LO=0 next edge. With MD_CANCEL_EN, cancel at cycle 3 instead -> busy=0 and prior HI/LO retained.
